keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
- Parametrised successor of the 4x4 keypad scanner: generic ROWS x COLS matrix, per-key debounce, true multi-key (n-key) tracking, make/break event queue with valid/ready handshake.
- Sits between the board keypad pins and the CPU I/O bus. Software pops events; the raw index-to-glyph mapping lives in software, not in this block.

Parameters:
ROWS, 4, number of driven rows (2..8)
COLS, 4, number of sensed columns (2..8)
SCAN_DIV, 262144, clk cycles each row is driven
SETTLE, 131072, cycle offset within a row dwell at which columns are sampled (0 < SETTLE < SCAN_DIV-1)
DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to flip a key's debounced state (1..15)
FIFO_DEPTH, 8, event queue depth (power of 2, >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
col  in  COLS  column sense, active-low, externally pulled up, asynchronous to clk
row  out  ROWS  row drive, one-hot active-low
ev_data  out  CODE_W+1  {break, code}: break=1 means release; code = r*COLS+c; CODE_W = clog2(ROWS*COLS)
ev_valid  out  1  queue non-empty
ev_ready  in  1  consumer pop; a pop occurs when ev_valid && ev_ready
key_down  out  1  OR of all debounced key states
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async assert, sync release): dwell counter=0, row index=0, row = all 1s except bit0=0, all debounced states=0, all debounce counters=0, FIFO empty, ev_valid=0, ev_data=0, key_down=0, ovf=0. Reset mid-scan or mid-handshake discards all queued events with no partial outputs.
- col passes through a 2-flop synchroniser before use.
- Dwell counter counts 0..SCAN_DIV-1. At wrap the row index advances and wraps ROWS-1 -> 0. row is registered and changes in the cycle following the wrap.
- Sample strobe fires when the dwell counter == SETTLE. It fires exactly once per row per frame and uses the synchronised col for the current row.
- Per-key debounce on each strobe, for each c in the current row r:
  - raw = !col_s[c].
  - raw == state: the key's counter clears to 0.
  - raw != state: the counter increments, saturating at DEBOUNCE_SCANS.
  - A key whose counter == DEBOUNCE_SCANS is pending.
- Commit on strobe: the lowest-c pending key in row r commits. Its state toggles, its counter clears, and event {!new_state, r*COLS+c} is pushed.
- Other pending keys in that row stay saturated and commit on later frames, one per row per frame. No event is ever lost to simultaneity.
- Queue: synchronous FIFO with show-ahead output. ev_data is valid whenever ev_valid=1 and holds stable until popped.
  - Push and pop in the same cycle: both occur, occupancy unchanged. This is legal even when full.
  - Pop when empty: ignored.
- Overflow: a push while full with no simultaneous pop drops the event and sets ovf. The key state still commits.
  - ovf_clr clears ovf. If ovf_clr and a new overflow occur in the same cycle, set wins.
- key_down is registered and updates the cycle after any commit.

Optional Feature:
- KEYPAD_REPEAT_EN defined: parameters REPEAT_DELAY (frames, default 50) and REPEAT_RATE (frames, default 10) are added.
  - While exactly one key is held, after REPEAT_DELAY frames a make event for that key is re-pushed, then again every REPEAT_RATE frames.
  - The repeat timer resets on any commit, and repeat stops when the held-key count is not exactly 1.
  - A repeat push and a commit push never coincide: the commit takes priority and that repeat is skipped.
- KEYPAD_REPEAT_EN undefined: no repeat logic; each key generates only one make and one break per press.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=16, SETTLE=8, DEBOUNCE_SCANS=2, FIFO_DEPTH=4):
- Reset, no keys -> row cycles 1110,1101,1011,0111 with 16 cycles each; ev_valid=0, key_down=0 throughout.
- Hold key r2,c1 for 4 frames, then release -> exactly one event 0x09 (make, code 9), then after release 0x19 (break); key_down high between the make and the break.
- Glitch r0,c3 for a single sample -> no event (counter clears before reaching 2).
- Press r1,c0 and r1,c2 simultaneously -> make 0x04 is committed one frame before make 0x06; both appear in order.
- Hold ev_ready=0 and generate 5 events -> 4 are queued, the 5th is dropped, ovf=1. Then pop all 4 in order, pulse ovf_clr, and ovf=0.
- Assert rst_n=0 with 3 events queued and a key mid-debounce -> ev_valid=0, ovf=0, row=1110 immediately. A key still held after release of rst_n produces a fresh make event after 2 frames.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS keypad scanner: row drive, per-key debounce, n-key tracking and a make/break event FIFO.
// Define KEYPAD_REPEAT_EN to add typematic repeat of a single held key.
module keypad_matrix_scanner #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 262144,
  parameter int unsigned SETTLE         = 131072,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 8,
`ifdef KEYPAD_REPEAT_EN
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_RATE    = 10,
`endif
  localparam int unsigned CODE_W        = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W:0]   ev_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              key_down,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned KEYS = ROWS * COLS;
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned DW   = $clog2(SCAN_DIV);
  localparam int unsigned CW   = 4;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = PW + 1;
  localparam int unsigned EW   = CODE_W + 1;

  logic [COLS-1:0] col_m, col_s;
  logic [DW-1:0]   dwell;
  logic [RW-1:0]   row_idx;
  logic            wrap, strobe;

  logic [KEYS-1:0] state, state_nxt;
  logic [CW-1:0]   cnt     [KEYS];
  logic [CW-1:0]   cnt_nxt [KEYS];
  logic            raw;
  logic            commit;
  logic [EW-1:0]   commit_ev;

  logic            push, push_ok, pop, overflow;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [NW-1:0]   count, count_nxt;
  logic [EW-1:0]   head_nxt;

  // Two-flop synchroniser for the asynchronous column inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  assign wrap   = (dwell == DW'(SCAN_DIV - 1));
  assign strobe = (dwell == DW'(SETTLE));

  // Row dwell timer; the row pins follow the row index one cycle after the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      row_idx <= '0;
      row     <= ~ROWS'(1);
    end else begin
      dwell <= wrap ? '0 : dwell + DW'(1);
      if (wrap) row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
      row <= ~(ROWS'(1) << row_idx);
    end
  end

  // Debounce the current row and commit its lowest-column pending key
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    raw       = 1'b0;
    commit    = 1'b0;
    commit_ev = '0;
    if (strobe) begin
      for (int k = 0; k < int'(KEYS); k++) begin
        if (RW'(k / COLS) == row_idx) begin
          raw = ~col_s[k % COLS];
          if (raw == state[k]) cnt_nxt[k] = '0;
          else if (cnt[k] != CW'(DEBOUNCE_SCANS)) cnt_nxt[k] = cnt[k] + CW'(1);
          if (!commit && cnt_nxt[k] == CW'(DEBOUNCE_SCANS)) begin
            commit       = 1'b1;
            state_nxt[k] = ~state[k];
            cnt_nxt[k]   = '0;
            commit_ev    = {state[k], CODE_W'(k)};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= '0;
      key_down <= 1'b0;
      for (int k = 0; k < int'(KEYS); k++) cnt[k] <= '0;
    end else begin
      state    <= state_nxt;
      key_down <= |state;
      for (int k = 0; k < int'(KEYS); k++) cnt[k] <= cnt_nxt[k];
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(RMAX + 1);

  logic [TW-1:0]     rpt_cnt, rpt_limit;
  logic              rpt_first, rpt_due, rpt_fire, frame_tick, single;
  logic [CODE_W:0]   nheld;
  logic [CODE_W-1:0] held_code;

  always_comb begin
    nheld     = '0;
    held_code = '0;
    for (int k = 0; k < int'(KEYS); k++) begin
      if (state[k]) begin
        nheld     = nheld + EW'(1);
        held_code = CODE_W'(k);
      end
    end
  end

  assign single     = (nheld == EW'(1));
  assign frame_tick = wrap && (row_idx == RW'(ROWS - 1));
  assign rpt_limit  = rpt_first ? TW'(REPEAT_DELAY) : TW'(REPEAT_RATE);
  assign rpt_due    = (rpt_cnt + TW'(1)) >= rpt_limit;
  assign rpt_fire   = frame_tick && single && rpt_due && !commit;

  // Frame counter for typematic repeat; any commit or multi/zero-key state restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (commit || !single) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (frame_tick) begin
      if (rpt_due) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + TW'(1);
      end
    end
  end

  always_comb begin
    push      = commit || rpt_fire;
    push_data = commit ? commit_ev : {1'b0, held_code};
  end
`else
  always_comb begin
    push      = commit;
    push_data = commit_ev;
  end
`endif

  assign pop      = ev_valid && ev_ready;
  assign push_ok  = push && ((count != NW'(FIFO_DEPTH)) || pop);
  assign overflow = push && !push_ok;

  // Next occupancy and the show-ahead head word for the registered output stage
  always_comb begin
    count_nxt = count;
    rd_nxt    = rd_ptr;
    head_nxt  = '0;
    if (push_ok && !pop) count_nxt = count + NW'(1);
    else if (!push_ok && pop) count_nxt = count - NW'(1);
    if (pop) rd_nxt = rd_ptr + PW'(1);
    if (count_nxt != '0) begin
      if (push_ok && ((count == '0) || (pop && count == NW'(1)))) head_nxt = push_data;
      else head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ev_valid <= 1'b0;
      ev_data  <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_nxt;
      count    <= count_nxt;
      ev_valid <= (count_nxt != '0);
      ev_data  <= head_nxt;
      if (overflow) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: directed table, corner sequences and random keys vs a reference model.
module tb_keypad_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SDIV  = 16;
  localparam int SETL  = 8;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = ROWS * SDIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col, row;
  logic [4:0] ev_data;
  logic       ev_valid, ev_ready, key_down, ovf, ovf_clr;
  bit  [15:0] pressed;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !row[r]) col[c] = 1'b0;
  end

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .SETTLE(SETL),
    .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .key_down(key_down), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc;
  bit         mst  [16];
  int         mcnt [16];
  logic [4:0] mq [$];
  bit         movf, mkd;
  logic [3:0] mrow;

  typedef struct {
    int         key;
    int         hold;
    logic [4:0] mk;
    logic [4:0] bk;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < 16; k++) begin
      mst[k]  = 1'b0;
      mcnt[k] = 0;
    end
    mq.delete();
    movf = 1'b0;
    mkd  = 1'b0;
    mrow = 4'b1110;
  endtask

  // Effect of one clock edge, from the key matrix and handshake inputs
  task automatic model_edge();
    int         d, r, k;
    bit         any, pushed, dropped;
    logic [4:0] ev;
    d = cyc % SDIV;
    r = (cyc / SDIV) % ROWS;
    any = 1'b0;
    for (int i = 0; i < 16; i++) any |= mst[i];
    pushed  = 1'b0;
    dropped = 1'b0;
    ev      = '0;
    if (d == SETL) begin
      for (int c = 0; c < COLS; c++) begin
        k = r * COLS + c;
        if (pressed[k] == mst[k]) mcnt[k] = 0;
        else if (mcnt[k] < DEB) mcnt[k]++;
      end
      for (int c = 0; c < COLS; c++) begin
        k = r * COLS + c;
        if (!pushed && mcnt[k] == DEB) begin
          mst[k]  = !mst[k];
          mcnt[k] = 0;
          pushed  = 1'b1;
          ev      = {!mst[k], 4'(k)};
        end
      end
    end
    if (mq.size() != 0 && ev_ready) void'(mq.pop_front());
    if (pushed) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else dropped = 1'b1;
    end
    if (dropped) movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
    mrow = 4'b1111 & ~(4'b0001 << r);
    mkd  = any;
    cyc++;
  endtask

  task automatic compare_all();
    chk("row", row, mrow);
    chk("ev_valid", ev_valid, mq.size() != 0);
    chk("ev_data", ev_data, (mq.size() != 0) ? mq[0] : 5'h00);
    chk("key_down", key_down, mkd);
    chk("ovf", ovf, movf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic align();
    while (cyc % FRAME != 0) tick();
  endtask

  task automatic pop_expect(input string name, input logic [4:0] exp);
    chk({name, "_valid"}, ev_valid, 1);
    chk(name, ev_data, exp);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{key: 9,  hold: 4, mk: 5'h09, bk: 5'h19};
    vt[1] = '{key: 0,  hold: 3, mk: 5'h00, bk: 5'h10};
    vt[2] = '{key: 15, hold: 3, mk: 5'h0F, bk: 5'h1F};
    vt[3] = '{key: 6,  hold: 2, mk: 5'h06, bk: 5'h16};
    vt[4] = '{key: 12, hold: 3, mk: 5'h0C, bk: 5'h1C};

    rst_n    = 1'b0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    pressed  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_row", row, 4'b1110);
    chk("reset_valid", ev_valid, 0);
    chk("reset_data", ev_data, 0);
    chk("reset_key_down", key_down, 0);
    chk("reset_ovf", ovf, 0);

    // Idle scanning with no keys
    run(2 * FRAME);

    // Single-key press/release table
    for (int i = 0; i < 5; i++) begin
      align();
      pressed[vt[i].key] = 1'b1;
      run(vt[i].hold * FRAME);
      chk("tbl_key_down_held", key_down, 1);
      pressed[vt[i].key] = 1'b0;
      run(4 * FRAME);
      pop_expect("tbl_make", vt[i].mk);
      pop_expect("tbl_break", vt[i].bk);
      chk("tbl_drained", ev_valid, 0);
      chk("tbl_key_down_released", key_down, 0);
    end

    // One-sample glitch on r0,c3
    align();
    pressed[3] = 1'b1;
    run(SDIV);
    pressed[3] = 1'b0;
    run(3 * FRAME);
    chk("glitch_no_event", ev_valid, 0);

    // Two keys in the same row commit one frame apart
    align();
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    run(5 * FRAME);
    pressed[4] = 1'b0;
    pressed[6] = 1'b0;
    run(5 * FRAME);
    pop_expect("simul_make4", 5'h04);
    pop_expect("simul_make6", 5'h06);
    pop_expect("simul_break4", 5'h14);
    pop_expect("simul_break6", 5'h16);
    chk("simul_drained", ev_valid, 0);

    // Five events into a four-deep queue
    align();
    pressed[0]  = 1'b1;
    pressed[5]  = 1'b1;
    pressed[10] = 1'b1;
    pressed[15] = 1'b1;
    pressed[3]  = 1'b1;
    run(4 * FRAME);
    chk("ovf_set", ovf, 1);
    pop_expect("ovf_pop0", 5'h00);
    pop_expect("ovf_pop1", 5'h05);
    pop_expect("ovf_pop2", 5'h0A);
    pop_expect("ovf_pop3", 5'h0F);
    chk("ovf_fifth_dropped", ev_valid, 0);
    chk("ovf_still_set", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    pressed  = '0;
    ev_ready = 1'b1;
    run(5 * FRAME);
    ev_ready = 1'b0;
    chk("ovf_drained", ev_valid, 0);

    // Reset with queued events and a key mid-debounce
    align();
    pressed[0]  = 1'b1;
    pressed[5]  = 1'b1;
    pressed[10] = 1'b1;
    run(2 * FRAME);
    chk("rst_pre_valid", ev_valid, 1);
    pressed[15] = 1'b1;
    run(FRAME + 20);
    pressed[5]  = 1'b0;
    pressed[10] = 1'b0;
    pressed[15] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", ev_valid, 0);
    chk("rst_async_ovf", ovf, 0);
    chk("rst_async_row", row, 4'b1110);
    chk("rst_async_key_down", key_down, 0);
    chk("rst_async_data", ev_data, 0);
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(3 * FRAME);
    chk("rst_fresh_valid", ev_valid, 1);
    chk("rst_fresh_make", ev_data, 5'h00);
    chk("rst_fresh_key_down", key_down, 1);
    pop_expect("rst_fresh_pop", 5'h00);
    pressed[0] = 1'b0;
    ev_ready   = 1'b1;
    run(4 * FRAME);
    ev_ready   = 1'b0;

    // Random keys, handshake and overflow clears against the model
    for (int n = 0; n < 40 * FRAME; n++) begin
      if (cyc % SDIV == 0 && $urandom_range(3) == 0) begin
        int idx;
        idx = int'($urandom_range(15));
        pressed[idx] = !pressed[idx];
      end
      ev_ready = ($urandom_range(2) == 0);
      ovf_clr  = ($urandom_range(31) == 0);
      tick();
    end
    ovf_clr  = 1'b0;
    pressed  = '0;
    ev_ready = 1'b1;
    run(5 * FRAME);
    chk("final_drained", ev_valid, 0);
    chk("final_key_down", key_down, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
